fetch_prefetch_stage: RTL and testbench

//  Parametrised IF stage: issues pipelined fetches on the SRAM-like req/addr_ok/data_ok bus with up to
//  MAX_OUTSTANDING requests in flight, buffers returned instructions in an IBUF_DEPTH-entry queue and

---
 rtl/fetch_prefetch_stage_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_prefetch_stage.sv | 86 ++++++++
 tb/tb_fetch_prefetch_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_stage_pkg.sv
// fetch_prefetch_stage_pkg: IF->ID bus layout shared by the fetch stage and its queues.
package fetch_prefetch_stage_pkg;
    localparam int WIDTH_FS_TO_DS_BUS = 65;
    localparam int BUS_PC_LSB         = 0;
    localparam int BUS_INST_LSB       = 32;
    localparam int BUS_ADEF_BIT       = 64;

    typedef struct packed {
        logic        adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with clear; head reads as zero when empty.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q == AW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q == AW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_q] <= data_i;
    end

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign count_o = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
endmodule

// File: rtl/fetch_prefetch_stage.sv
// fetch_prefetch_stage: pipelined IF stage with outstanding-request tracking, count-based
// discard of stale responses after redirects, and an instruction buffer towards ID.
module fetch_prefetch_stage
    import fetch_prefetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h1C000000,
    parameter int          IBUF_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [31:0]                   flush_pc,
    input  logic                          br_taken,
    input  logic [31:0]                   br_target,
    input  logic                          br_stall,
    input  logic                          ds_allow_in,
    output logic                          fs_to_ds_valid,
    output logic [WIDTH_FS_TO_DS_BUS-1:0] fs_to_ds_bus,
    output logic                          inst_sram_req,
    output logic [31:0]                   inst_sram_addr,
    input  logic                          inst_sram_addr_ok,
    input  logic                          inst_sram_data_ok,
    input  logic [31:0]                   inst_sram_rdata
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = $clog2(IBUF_DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic          adef_hold_q, adef_hold_d;
    logic [OW-1:0] inflight_q, inflight_d, discard_q, discard_d, pcq_cnt;
    logic [BW-1:0] ibuf_cnt;
    logic [31:0]   pcq_head;
    logic          redirect, misaligned, acc, keep, adef_push;
    logic          pcq_full, pcq_empty, ibuf_full, ibuf_empty, ibuf_pop;
    fs_entry_t     ibuf_din, ibuf_dout;
    logic          unused;

    assign redirect       = flush | br_taken;
    assign misaligned     = pc_q[1:0] != 2'b00;
    assign inst_sram_req  = !reset && !br_stall && !adef_hold_q && !redirect && !misaligned
                            && int'(inflight_q) < MAX_OUTSTANDING
                            && int'(ibuf_cnt) + int'(inflight_q) < IBUF_DEPTH;
    assign inst_sram_addr = reset ? '0 : pc_q;
    assign acc            = inst_sram_req & inst_sram_addr_ok;
    // responses owed to a pre-redirect request never reach the pc queue or ibuf
    assign keep           = inst_sram_data_ok && discard_q == '0 && !redirect;
    assign adef_push      = misaligned && !adef_hold_q && !redirect && pcq_empty && !ibuf_full;
    assign ibuf_din       = adef_push ? '{adef: 1'b1, inst: 32'h0, pc: pc_q}
                                      : '{adef: 1'b0, inst: inst_sram_rdata, pc: pcq_head};
    assign fs_to_ds_valid = !ibuf_empty && !redirect;
    assign ibuf_pop       = fs_to_ds_valid & ds_allow_in;
    assign fs_to_ds_bus   = ibuf_dout;
    assign unused         = ^{pcq_full, pcq_cnt};

    always_comb begin
        inflight_d  = inflight_q + OW'(acc) - OW'(inst_sram_data_ok);
        discard_d   = redirect ? inflight_d : discard_q - OW'(inst_sram_data_ok && discard_q != '0);
        pc_d        = flush ? flush_pc : br_taken ? br_target : acc ? pc_q + 32'd4 : pc_q;
        adef_hold_d = !redirect && (adef_hold_q || adef_push);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            adef_hold_q <= 1'b0;
            inflight_q  <= '0;
            discard_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            adef_hold_q <= adef_hold_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
        end
    end

    fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pcq (
        .clk(clk), .rst(reset), .clr_i(redirect), .push_i(acc), .pop_i(keep),
        .data_i(pc_q), .data_o(pcq_head), .full_o(pcq_full), .empty_o(pcq_empty), .count_o(pcq_cnt)
    );

    fetch_fifo #(.WIDTH(WIDTH_FS_TO_DS_BUS), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk(clk), .rst(reset), .clr_i(redirect), .push_i(keep | adef_push), .pop_i(ibuf_pop),
        .data_i(ibuf_din), .data_o(ibuf_dout), .full_o(ibuf_full), .empty_o(ibuf_empty), .count_o(ibuf_cnt)
    );
endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// tb_fetch_prefetch_stage: randomized bus/ID stimulus against a stream-level model of the fetch stage.
module tb_fetch_prefetch_stage;
    localparam logic [31:0] RPC = 32'h1C000000;
    localparam int MO = 2;

    logic        clk = 0, reset = 1, flush = 0, br_taken = 0, br_stall = 0, ds_allow_in = 0;
    logic        addr_ok = 0, data_ok = 0;
    logic [31:0] flush_pc = 0, br_target = 0, rdata = 0, addr;
    logic        fs_valid, req;
    logic [64:0] bus;

    fetch_prefetch_stage #(.RESET_PC(RPC), .IBUF_DEPTH(4), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc), .br_taken(br_taken),
        .br_target(br_target), .br_stall(br_stall), .ds_allow_in(ds_allow_in),
        .fs_to_ds_valid(fs_valid), .fs_to_ds_bus(bus), .inst_sram_req(req), .inst_sram_addr(addr),
        .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(rdata)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, delivered = 0, adefs = 0;
    int pa, pk, pd, pf, pb, ps, pm;
    logic        fl_now = 0, br_now = 0, dead = 0;
    logic [31:0] fl_t, br_t, f_pc = RPC, e_pc = RPC;
    logic [31:0] mq[$];

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    task automatic knobs(input int a, input int k, input int d, input int f, input int b, input int s, input int m);
        pa = a; pk = k; pd = d; pf = f; pb = b; ps = s; pm = m;
    endtask

    // One bus cycle: drive at negedge, check 1ns later, then advance the model to match the posedge.
    task automatic cyc();
        logic [31:0] t;
        @(negedge clk);
        flush    = fl_now || ($urandom % 1000) < pf;
        flush_pc = fl_now ? fl_t : RPC | ($urandom & 32'h0000FFFC);
        br_taken = br_now || ($urandom % 1000) < pb;
        t        = RPC | ($urandom & 32'h0000FFFC);
        br_target = br_now ? br_t : (($urandom % 100) < pm ? t | 32'($urandom_range(1, 3)) : t);
        br_stall    = ($urandom % 100) < ps;
        ds_allow_in = ($urandom % 100) < pa;
        addr_ok     = ($urandom % 100) < pk;
        data_ok     = mq.size() > 0 && ($urandom % 100) < pd;
        rdata       = data_ok ? mem(mq[0]) : $urandom;
        fl_now = 0;
        br_now = 0;
        #1;
        if (flush | br_taken) begin
            chk("redirect_valid", fs_valid, 0);
            chk("redirect_req", req, 0);
        end else if (!fs_valid) chk("empty_bus", bus, 0);
        if (req) chk("req_addr", addr, f_pc);
        if (fs_valid && ds_allow_in) begin
            if (dead) chk("entry_after_adef", fs_valid, 0);
            else if (e_pc[1:0] != 2'b00) begin
                chk("adef_entry", bus, {1'b1, 32'h0, e_pc});
                dead = 1;
                adefs++;
            end else begin
                chk("entry", bus, {1'b0, mem(e_pc), e_pc});
                e_pc += 4;
                delivered++;
            end
        end
        if (req && addr_ok) begin
            mq.push_back(addr);
            f_pc += 4;
        end
        if (data_ok) void'(mq.pop_front());
        if (flush | br_taken) begin
            f_pc = flush ? flush_pc : br_target;
            e_pc = f_pc;
            dead = 0;
        end
        chk("inflight_bound", mq.size() <= MO, 1);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc);
        for (int i = 0; i < 20 && !fs_valid; i++) cyc();
        chk(tag, {fs_valid, bus[31:0]}, {1'b1, pc});
    endtask

    int d0, a0;

    initial begin
        knobs(100, 100, 100, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", req, 0);
        chk("rst_valid", fs_valid, 0);
        chk("rst_bus", bus, 0);
        chk("rst_addr", addr, 0);
        @(negedge clk);
        reset = 0;
        #1;
        chk("first_req", {req, addr}, {1'b1, RPC});
        // back-to-back: one instruction per cycle once the pipe is warm
        run(10);
        d0 = delivered;
        run(20);
        chk("b2b_rate", delivered - d0, 20);
        // backpressure: ibuf fills, issue stops, then exactly IBUF_DEPTH drain in order
        knobs(0, 100, 100, 0, 0, 0, 0);
        run(20);
        chk("bp_req_drop", req, 0);
        chk("bp_valid", fs_valid, 1);
        knobs(100, 0, 100, 0, 0, 0, 0);
        d0 = delivered;
        run(10);
        chk("bp_drain", delivered - d0, 4);
        // flush with two requests in flight
        knobs(100, 100, 0, 0, 0, 0, 0);
        run(3);
        chk("two_inflight", mq.size(), 2);
        fl_now = 1;
        fl_t = 32'h1C008000;
        cyc();
        pd = 100;
        wait_valid("flush_first_pc", 32'h1C008000);
        run(5);
        // flush coinciding with a response
        pd = 0;
        run(3);
        pd = 100;
        fl_now = 1;
        fl_t = 32'h1C00C000;
        cyc();
        chk("flush_with_data_ok", data_ok, 1);
        wait_valid("flush2_first_pc", 32'h1C00C000);
        run(5);
        // misaligned branch target: one adef entry, then silence until a redirect
        a0 = adefs;
        br_now = 1;
        br_t = 32'h1C000102;
        run(12);
        chk("adef_once", adefs - a0, 1);
        chk("adef_no_req", req, 0);
        fl_now = 1;
        fl_t = 32'h1C000200;
        d0 = delivered;
        run(10);
        chk("resume_after_adef", delivered > d0, 1);
        // reset mid-burst
        run(4);
        @(negedge clk);
        #2;
        reset = 1;
        flush = 0; br_taken = 0; addr_ok = 0; data_ok = 0;
        #1;
        chk("midrst_out", {req, fs_valid, bus, addr}, '0);
        mq.delete();
        f_pc = RPC; e_pc = RPC; dead = 0;
        @(negedge clk);
        reset = 0;
        #1;
        chk("midrst_req", {req, addr}, {1'b1, RPC});
        wait_valid("midrst_first_pc", RPC);
        // random mix
        knobs(75, 70, 60, 20, 30, 12, 20);
        d0 = delivered;
        run(4000);
        chk("random_progress", delivered - d0 > 200, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
